// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the byte-serial subtractor.
// Overflow output is enabled by defining SERIAL_SUB_OVF_EN.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BYTE_W = 8;

  // Byte-index counter width; a single-byte build still needs one bit.
  function automatic int idx_w(input int bytes);
    return (bytes <= 1) ? 1 : $clog2(bytes);
  endfunction

endpackage

// File: rtl/serial_sub_byte.sv
// Combinational 8-bit subtract slice: diff = a - b - bin, with borrow-out
// and the borrow into the slice MSB (for signed overflow detection).
module sub_byte
  import serial_sub_pkg::*;
(
  input  logic [BYTE_W-1:0] a_byte,
  input  logic [BYTE_W-1:0] b_byte,
  input  logic              bin,
  output logic [BYTE_W-1:0] diff,
  output logic              bout,
  output logic              msb_bin
);

  logic [BYTE_W:0]   full;
  logic [BYTE_W-1:0] low;

  always_comb begin
    full    = {1'b0, a_byte} - {1'b0, b_byte} - {{BYTE_W{1'b0}}, bin};
    // Subtracting only the low 7 bits exposes the borrow into bit 7 at bit 7.
    low     = {1'b0, a_byte[BYTE_W-2:0]} - {1'b0, b_byte[BYTE_W-2:0]}
              - {{(BYTE_W-1){1'b0}}, bin};
    diff    = full[BYTE_W-1:0];
    bout    = full[BYTE_W];
    msb_bin = low[BYTE_W-1];
  end

endmodule

// File: rtl/serial_sub.sv
// Byte-serial subtractor d = a - b - bin, one byte per clock, valid/ready on both sides.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int BYTES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BYTES*BYTE_W-1:0]   a,
  input  logic [BYTES*BYTE_W-1:0]   b,
  input  logic                      bin,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BYTES*BYTE_W-1:0]   d,
  output logic                      bout,
`ifdef SERIAL_SUB_OVF_EN
  output logic                      ovf,
`endif
  output state_t                    dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; ready and valid are registered, and no input reaches any output
  // combinationally. Inputs are sampled only in IDLE, out_ready only in DONE.

  localparam int W   = BYTES * BYTE_W;
  localparam int K_W = idx_w(BYTES);
  localparam logic [K_W-1:0] K_LAST = K_W'(BYTES - 1);

  state_t           state, state_nx;
  logic [W-1:0]     a_sh, b_sh, d_r, d_shift;
  logic             borrow;
  logic [K_W-1:0]   k;
  logic             in_ready_r, out_valid_r, bout_r;
  logic             accept, release_out;

  logic [BYTE_W-1:0] slice_diff;
  logic              slice_bout;
`ifdef SERIAL_SUB_OVF_EN
  logic              slice_msb;
  logic              ovf_r;
`else
  logic              slice_msb_unused;
`endif

  sub_byte u_slice (
    .a_byte  (a_sh[BYTE_W-1:0]),
    .b_byte  (b_sh[BYTE_W-1:0]),
    .bin     (borrow),
    .diff    (slice_diff),
    .bout    (slice_bout),
`ifdef SERIAL_SUB_OVF_EN
    .msb_bin (slice_msb)
`else
    .msb_bin (slice_msb_unused)
`endif
  );

  assign accept      = in_valid && in_ready_r;
  assign release_out = out_valid_r && out_ready;

  // New byte enters at the MSB end; after BYTES shifts byte 0 sits at the bottom.
  assign d_shift = (d_r >> BYTE_W) | (W'(slice_diff) << (W - BYTE_W));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (k == K_LAST) state_nx = DONE;
      DONE:    if (release_out) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      a_sh        <= '0;
      b_sh        <= '0;
      d_r         <= '0;
      borrow      <= 1'b0;
      k           <= '0;
      bout_r      <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_r       <= 1'b0;
`endif
    end else begin
      in_ready_r  <= (state_nx == IDLE);
      out_valid_r <= (state_nx == DONE);
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            borrow <= bin;
            k      <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> BYTE_W;
          b_sh   <= b_sh >> BYTE_W;
          d_r    <= d_shift;
          borrow <= slice_bout;
          k      <= k + 1'b1;
          // The final borrow is the value the borrow register takes on this edge.
          if (k == K_LAST) begin
            bout_r <= slice_bout;
`ifdef SERIAL_SUB_OVF_EN
            ovf_r  <= slice_msb ^ slice_bout;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign d         = d_r;
  assign bout      = bout_r;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf       = ovf_r;
`endif
  assign dbg_state = state;

endmodule
